vga_console_ctrl: RTL
=====================

// Module: vga_console_ctrl
// PURPOSE
//  Terminal-style controller for the 80x25 VGA text buffer on the CPU bus.
//  Bus writes go into a 16-entry command FIFO. A sequencer FSM drains it and
//  drives the text buffer's char/position/strobe write port.
//  It interprets control codes (LF, CR, BS, FF) and performs line/screen
//  clears, so software only issues bytes.
// PARAMETERS
//  BASE_ADDR   16'h8400  bus base; decode on addr[15:4]
//  COLS        80        characters per row
//  ROWS        25        rows; COLS*ROWS must be <= 2048
//  FIFO_DEPTH  16        command FIFO entries (power of 2)
// PORTS
//  i_clk             in   1   16 MHz system clock
//  i_rst_n           in   1   synchronous reset, active low
//  read_addr         in   16  bus read address
//  read_data         out  16  status when addressed, else 16'hzzzz
//  write_addr        in   16  bus write address
//  write_data        in   16  bus write data
//  write_strobe      in   1   bus write qualifier, 1 cycle
//  write_char        out  8   char to the text buffer
//  write_char_pos    out  11  linear buffer position, row*COLS+col
//  write_char_strobe out  1   1-cycle buffer write pulse
// BEHAVIOUR
//  Address map (write):
//   +0  char byte (data[7:0])
//   +1  set cursor: data[15:8]=row, data[7:0]=col
//   +2  clear overflow flag
//  Address map (read, any addr in block):
//   {ovf, busy, fifo_full, 2'b0, cursor_pos[10:0]}
//   busy = FSM not IDLE or FIFO non-empty.
//  Reset: FIFO empty; row=col=cursor_pos=0; ovf=0; FSM=IDLE;
//   write_char=0, write_char_pos=0, write_char_strobe=0.
//   Reset mid-clear aborts immediately; no further strobes.
//  FIFO: entry={type[1:0], data[15:0]}. Push on decoded +0/+1 write.
//   Push while full is dropped and sets ovf (sticky). +2 is not queued.
//   A pop and a push in the same cycle are both honoured.
//  Latency: push at edge N; IDLE pops at edge N+1; strobe high in cycle N+2.
//  Strobe spacing: every strobe is followed by >=1 low cycle.
//   Required: the buffer runs on an unrelated 40 MHz clock.
//  FSM states: IDLE, PUT, GAP, CLR_LINE, CLR_SCREEN.
//  IDLE: FIFO non-empty -> pop and decode:
//   printable (any byte except 0x08/0x0A/0x0C/0x0D):
//     -> PUT: strobe char at cursor, col+1. If col reaches COLS, do LF.
//   0x0D CR: col=0. No strobe. Back to IDLE.
//   0x0A LF: col=0; row+1, wrapping ROWS-1 -> 0. Then CLR_LINE.
//   0x08 BS: col>0 -> col-1, strobe 0x20 at new pos. col==0 -> no-op.
//   0x0C FF -> CLR_SCREEN.
//   set-cursor: row<ROWS and col<COLS -> load it, else cursor=0. No strobe.
//  CLR_LINE: COLS strobes of 0x20 at row*COLS .. row*COLS+COLS-1,
//   then IDLE. Takes 2*COLS cycles.
//  CLR_SCREEN: strobes 0x20 at 0..COLS*ROWS-1, then cursor=0 and IDLE.
//   Takes 2*COLS*ROWS cycles.
//  No scrolling: the buffer is write-only, so a new line wraps to the top
//   and that line is cleared.
//  cursor_pos = row*COLS+col, updated incrementally (no multiplier);
//   it wraps to 0 after position COLS*ROWS-1.
//  GAP: one idle cycle after each strobe, then return to the caller state.
//  Bus writes during a clear are queued, not lost, unless the FIFO is full.
// TESTING
//  1 reset; write 'A' to +0 -> strobe in cycle N+2, char=0x41, pos=0;
//    status cursor=1.
//  2 cursor to row2/col79; write 'Z' -> 'Z' at pos 239; then 80 space
//    strobes at 240..319; cursor=240.
//  3 row24 + LF -> row wraps to 0; spaces at 0..79; cursor=0.
//  4 FF -> exactly 2000 strobes, 0x20 at 0..1999, never back-to-back;
//    busy drops; cursor=0.
//  5 during FF, push 17 chars -> 16 kept in order after clear; ovf=1;
//    write +2 -> ovf=0.
//  6 BS at col0 -> no strobe; CR at col5 -> col0, no strobe;
//    reset mid-CLR_SCREEN -> strobe low, status 0 next cycle.

Source files
------------

// File: rtl/vga_console_ctrl.sv
`timescale 1ns/1ps
// Terminal-style front end for the 80x25 text buffer: bus writes are queued,
// then a sequencer turns bytes and control codes into paced buffer writes.
module vga_console_ctrl #(
  parameter logic [15:0] BASE_ADDR  = 16'h8400,
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] read_addr,
  output logic [15:0] read_data,
  input  logic [15:0] write_addr,
  input  logic [15:0] write_data,
  input  logic        write_strobe,
  output logic [7:0]  write_char,
  output logic [10:0] write_char_pos,
  output logic        write_char_strobe
);

  localparam int NPOS = COLS * ROWS;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int LW   = $clog2(NPOS + 1);
  localparam int PW   = 11;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [7:0]    COLS8    = 8'(COLS);
  localparam logic [7:0]    ROWS8    = 8'(ROWS);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [1:0]    T_CHAR   = 2'd0;
  localparam logic [1:0]    T_CURSOR = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_GAP,
    S_CLR_LINE,
    S_CLR_SCREEN
  } state_t;

  state_t         state;
  state_t         gap_ret;
  logic           put_lf;
  logic [17:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           ovf;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [PW-1:0]  row_base;
  logic [PW-1:0]  clr_pos;
  logic [LW-1:0]  clr_left;

  logic           wr_blk;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           ovf_clr;
  logic           full;
  logic           busy;
  logic [17:0]    pop_entry;
  logic [1:0]     pop_type;
  logic [15:0]    pop_data;
  logic [7:0]     pop_byte;
  logic [PW-1:0]  cursor_pos;
  logic [RW-1:0]  row_nx;
  logic [PW-1:0]  base_nx;
  logic           unused_ok;

  assign wr_blk   = write_strobe && (write_addr[15:4] == BASE_ADDR[15:4]);
  assign push_req = wr_blk && (write_addr[3:1] == 3'b000);
  assign ovf_clr  = wr_blk && (write_addr[3:0] == 4'd2);
  assign full     = (count == CNT_FULL);
  assign push     = push_req && !full;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign busy     = (state != S_IDLE) || (count != '0);

  assign pop_entry = fifo_mem[rd_ptr];
  assign pop_type  = pop_entry[17:16];
  assign pop_data  = pop_entry[15:0];
  assign pop_byte  = pop_data[7:0];

  // Row base is tracked alongside row so the linear position needs only an add.
  assign cursor_pos = row_base + PW'(col);
  assign row_nx     = (row == ROW_LAST) ? '0 : row + RW'(1);
  assign base_nx    = (row == ROW_LAST) ? '0 : row_base + PW'(COLS);

  assign read_data = (read_addr[15:4] == BASE_ADDR[15:4])
                   ? {ovf, busy, full, 2'b00, cursor_pos} : 16'hzzzz;
  assign unused_ok = &{1'b0, read_addr[3:0]};

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= {1'b0, write_addr[0], write_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      ovf               <= 1'b0;
      state             <= S_IDLE;
      gap_ret           <= S_IDLE;
      put_lf            <= 1'b0;
      row               <= '0;
      col               <= '0;
      row_base          <= '0;
      clr_pos           <= '0;
      clr_left          <= '0;
      write_char        <= '0;
      write_char_pos    <= '0;
      write_char_strobe <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
      if (ovf_clr)             ovf <= 1'b0;
      else if (push_req && full) ovf <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            case (pop_type)
              T_CHAR: begin
                case (pop_byte)
                  8'h0D: col <= '0;
                  8'h0A: begin
                    col      <= '0;
                    row      <= row_nx;
                    row_base <= base_nx;
                    clr_pos  <= base_nx;
                    clr_left <= LW'(COLS);
                    state    <= S_CLR_LINE;
                  end
                  8'h08: begin
                    if (col != '0) begin
                      col               <= col - CW'(1);
                      write_char_strobe <= 1'b1;
                      write_char        <= 8'h20;
                      write_char_pos    <= cursor_pos - PW'(1);
                      put_lf            <= 1'b0;
                      state             <= S_PUT;
                    end
                  end
                  8'h0C: begin
                    clr_pos  <= '0;
                    clr_left <= LW'(NPOS);
                    state    <= S_CLR_SCREEN;
                  end
                  default: begin
                    write_char_strobe <= 1'b1;
                    write_char        <= pop_byte;
                    write_char_pos    <= cursor_pos;
                    state             <= S_PUT;
                    // Running off the right edge behaves as LF: next row, then clear it.
                    if (col == COL_LAST) begin
                      col      <= '0;
                      row      <= row_nx;
                      row_base <= base_nx;
                      clr_pos  <= base_nx;
                      clr_left <= LW'(COLS);
                      put_lf   <= 1'b1;
                    end else begin
                      col    <= col + CW'(1);
                      put_lf <= 1'b0;
                    end
                  end
                endcase
              end
              T_CURSOR: begin
                if ((pop_data[15:8] < ROWS8) && (pop_data[7:0] < COLS8)) begin
                  row      <= RW'(pop_data[15:8]);
                  col      <= CW'(pop_data[7:0]);
                  row_base <= PW'(pop_data[15:8]) * PW'(COLS);
                end else begin
                  row      <= '0;
                  col      <= '0;
                  row_base <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        S_PUT: begin
          write_char_strobe <= 1'b0;
          state             <= put_lf ? S_CLR_LINE : S_IDLE;
        end
        S_CLR_LINE, S_CLR_SCREEN: begin
          write_char_strobe <= 1'b1;
          write_char        <= 8'h20;
          write_char_pos    <= clr_pos;
          clr_pos           <= clr_pos + PW'(1);
          clr_left          <= clr_left - LW'(1);
          state             <= S_GAP;
          if (clr_left == LW'(1)) begin
            gap_ret <= S_IDLE;
            if (state == S_CLR_SCREEN) begin
              row      <= '0;
              col      <= '0;
              row_base <= '0;
            end
          end else begin
            gap_ret <= state;
          end
        end
        S_GAP: begin
          write_char_strobe <= 1'b0;
          state             <= gap_ret;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
